ps2_kb_receiver: RTL and testbench

Parametrised PS/2 keyboard receiver. It runs entirely in the system clock domain and oversamples the PS/2 clock and data lines through synchronisers and a glitch filter. Each 11-bit frame is checked for start, odd parity and stop bits, with an inactivity timeout. Optional decoding merges E0/F0 prefixes into flags, and results are buffered in a first-word-fall-through FIFO for the consumer (display/command logic).

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/ps2_kb_receiver.sv | 240 ++++++++++++++++++++++++
 tb/tb_ps2_kb_receiver.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   PS2_EXT / PS2_BRK : prefix scan codes merged into the ext/brk flags
//   ps2_state_e       : frame FSM states
//   ps2_entry_t       : one FIFO entry {brk, ext, code[7:0]}
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_entry_t;

  localparam int ENTRY_W = $bits(ps2_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_en/wr_data: push request and data
//   rd_en        : pop head; ignored while empty
//   rd_data      : head entry (valid while empty=0)
//   empty/full   : registered occupancy flags after this cycle's push/pop
//   wr_drop      : push refused because full and no pop this cycle
// A simultaneous push and pop always succeeds, including when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             wr_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_n;
  logic             do_rd;
  logic             do_wr;

  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign wr_drop = wr_en & full & ~do_rd;
  assign rd_data = mem[rd_ptr];

  // NOTE: every variable in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    count_n = count;
    if (do_wr && !do_rd) begin
      count_n = count + 1'b1;
    end else if (do_rd && !do_wr) begin
      count_n = count - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      empty <= (count_n == '0);
      full  <= (count_n == DEPTH_V);
    end
  end

  // NOTE: the storage array has no reset; the pointers and flags define which
  // entries are meaningful, and the consumer masks the head while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_kb_receiver.sv
// PS/2 keyboard receiver running entirely in the system clock domain.
//   clk, reset_n   : system clock, asynchronous active-low reset
//   ps2_clk/data   : raw asynchronous PS/2 pins
//   rd_en          : pop the FIFO head (ignored when avail=0)
//   code/ext/brk   : head entry, zero while avail=0
//   avail/full     : FIFO not empty / FIFO full
//   err_parity     : one-cycle pulse, odd-parity failure
//   err_frame      : one-cycle pulse, bad start, bad stop or timeout
//   overflow       : one-cycle pulse, valid entry dropped because FIFO full
//   busy           : frame FSM not idle
// Pins pass a 2-flop synchroniser; ps2_clk is then debounced by requiring
// FILTER_LEN equal samples. Each filtered falling edge samples ps2_data into
// the frame FSM. With DECODE=1 the E0/F0 prefixes become ext/brk flags.
module ps2_kb_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000,
  parameter int FIFO_DEPTH  = 8,
  parameter int DECODE      = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] code,
  output logic       ext,
  output logic       brk,
  output logic       avail,
  output logic       full,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TIME_LAST = TW'(TIMEOUT_CYC - 1);

  // Input path
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          fall_bit;

  // Lines idle high, so the synchronisers reset to 1 and no edge is seen
  // when reset releases on an idle bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // filt_cnt counts consecutive samples that disagree with the accepted
  // level; the level flips on the FILTER_LEN-th one. fall_bit tracks data
  // every cycle, so on the cycle fall is high it holds the bit sampled at
  // the moment the clock level flipped low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
      fall_bit <= 1'b1;
    end else begin
      fall     <= 1'b0;
      fall_bit <= data_sync[1];
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
        fall     <= ~clk_sync[1];
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Frame FSM and decode
  ps2_state_e    state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par_bit, par_n;
  logic [TW-1:0] timer, timer_n;
  logic          ext_pend, ext_pend_n;
  logic          brk_pend, brk_pend_n;
  logic          push_q, push_n;
  ps2_entry_t    entry_q, entry_n;
  logic          err_par_q, err_par_n;
  logic          err_frm_q, err_frm_n;
  logic          timeout;
  logic          byte_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      timer     <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      push_q    <= 1'b0;
      entry_q   <= '0;
      err_par_q <= 1'b0;
      err_frm_q <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      par_bit   <= par_n;
      timer     <= timer_n;
      ext_pend  <= ext_pend_n;
      brk_pend  <= brk_pend_n;
      push_q    <= push_n;
      entry_q   <= entry_n;
      err_par_q <= err_par_n;
      err_frm_q <= err_frm_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    par_n      = par_bit;
    ext_pend_n = ext_pend;
    brk_pend_n = brk_pend;
    push_n     = 1'b0;
    entry_n    = entry_q;
    err_par_n  = 1'b0;
    err_frm_n  = 1'b0;
    byte_ok    = 1'b0;

    // timer counts cycles since the last filtered edge; an edge on the
    // limit cycle wins over the timeout.
    timeout = (state != ST_IDLE) && !fall && (timer == TIME_LAST);
    if (fall) begin
      timer_n = TW'(1);
    end else if (state == ST_IDLE) begin
      timer_n = '0;
    end else begin
      timer_n = timer + 1'b1;
    end

    if (timeout) begin
      err_frm_n = 1'b1;
      state_n   = ST_IDLE;
    end else if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!fall_bit) begin
            state_n   = ST_DATA;
            bit_cnt_n = '0;
          end else begin
            err_frm_n = 1'b1;
          end
        end
        ST_DATA: begin
          shift_n   = {fall_bit, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end
        ST_PARITY: begin
          par_n   = fall_bit;
          state_n = ST_STOP;
        end
        ST_STOP: begin
          state_n = ST_IDLE;
          if (!fall_bit) begin
            err_frm_n = 1'b1;
          end else if (!(^{shift, par_bit})) begin
            err_par_n = 1'b1;
          end else begin
            byte_ok = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    if (err_par_n || err_frm_n) begin
      ext_pend_n = 1'b0;
      brk_pend_n = 1'b0;
    end else if (byte_ok) begin
      if (DECODE != 0 && shift == PS2_EXT) begin
        ext_pend_n = 1'b1;
      end else if (DECODE != 0 && shift == PS2_BRK) begin
        brk_pend_n = 1'b1;
      end else begin
        push_n       = 1'b1;
        entry_n.code = shift;
        entry_n.ext  = (DECODE != 0) ? ext_pend : 1'b0;
        entry_n.brk  = (DECODE != 0) ? brk_pend : 1'b0;
        ext_pend_n   = 1'b0;
        brk_pend_n   = 1'b0;
      end
    end
  end

  // Output FIFO
  logic [ENTRY_W-1:0] head_bits;
  ps2_entry_t         head;
  logic               fifo_empty;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push_q),
    .wr_data (entry_q),
    .rd_en   (rd_en),
    .rd_data (head_bits),
    .empty   (fifo_empty),
    .full    (full),
    .wr_drop (overflow)
  );

  assign head       = ps2_entry_t'(head_bits);
  assign avail      = ~fifo_empty;
  // Unread storage is never reset, so the head is masked while empty.
  assign code       = avail ? head.code : 8'h00;
  assign ext        = avail & head.ext;
  assign brk        = avail & head.brk;
  assign err_parity = err_par_q;
  assign err_frame  = err_frm_q;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_ps2_kb_receiver.sv
// Bench for ps2_kb_receiver: a decoding instance (index 0) and a raw
// instance (index 1) share the PS/2 pins. Stimulus pushes expected entries
// and error events into per-instance queues; a monitor pops and compares
// whenever a DUT presents data or pulses an error.
module tb_ps2_kb_receiver;

  localparam int F     = 4;
  localparam int T     = 200;
  localparam int DEPTH = 8;
  localparam int HALF  = 12;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;
  logic [1:0] rd_en = '0;
  logic [1:0][7:0] code;
  logic [1:0] ext, brk, avail, full, err_parity, err_frame, overflow, busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_kb_receiver #(.FILTER_LEN(F), .TIMEOUT_CYC(T), .FIFO_DEPTH(DEPTH), .DECODE(1)) u_dec (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en[0]),
    .code(code[0]), .ext(ext[0]), .brk(brk[0]), .avail(avail[0]), .full(full[0]),
    .err_parity(err_parity[0]), .err_frame(err_frame[0]), .overflow(overflow[0]), .busy(busy[0]));

  ps2_kb_receiver #(.FILTER_LEN(F), .TIMEOUT_CYC(T), .FIFO_DEPTH(DEPTH), .DECODE(0)) u_raw (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en[1]),
    .code(code[1]), .ext(ext[1]), .brk(brk[1]), .avail(avail[1]), .full(full[1]),
    .err_parity(err_parity[1]), .err_frame(err_frame[1]), .overflow(overflow[1]), .busy(busy[1]));

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model state. Entries are {brk, ext, code}; event kinds are
  // 1 = parity error, 2 = frame error, 3 = overflow.
  logic [9:0] exp_q [2][$];
  int ev_kind [2][$];
  int ev_cyc  [2][$];
  bit ext_p [2];
  bit brk_p [2];
  bit read_on = 1'b0;
  int rise_cyc [2];
  bit prev_avail [2];

  task automatic add_ev(input int d, input int k, input int c);
    ev_kind[d].push_back(k);
    ev_cyc[d].push_back(c);
    ext_p[d] = 1'b0;
    brk_p[d] = 1'b0;
  endtask

  // A completed frame, its stop bit falling on pin cycle 'fall'. Errors and
  // pushes both surface F+3 cycles after the pin edge.
  task automatic model_byte(input logic [7:0] b, input bit par_ok, input bit stop_ok, input int fall);
    for (int d = 0; d < 2; d++) begin
      if (!stop_ok) add_ev(d, 2, fall + F + 3);
      else if (!par_ok) add_ev(d, 1, fall + F + 3);
      else if (d == 0 && b == 8'hE0) ext_p[d] = 1'b1;
      else if (d == 0 && b == 8'hF0) brk_p[d] = 1'b1;
      else begin
        logic [9:0] e;
        e = (d == 0) ? {brk_p[d], ext_p[d], b} : {2'b00, b};
        ext_p[d] = 1'b0;
        brk_p[d] = 1'b0;
        if (exp_q[d].size() >= DEPTH && !read_on) add_ev(d, 3, fall + F + 3);
        else exp_q[d].push_back(e);
      end
    end
  endtask

  task automatic model_timeout(input int fall);
    for (int d = 0; d < 2; d++) add_ev(d, 2, fall + F + 2 + T);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      ev_kind[d].delete();
      ev_cyc[d].delete();
      ext_p[d] = 1'b0;
      brk_p[d] = 1'b0;
    end
  endtask

  task automatic take_ev(input int d, input int k);
    if (ev_kind[d].size() == 0) begin
      check($sformatf("unexpected_event[%0d]", d), k, 0);
    end else begin
      int ek, ec;
      ek = ev_kind[d].pop_front();
      ec = ev_cyc[d].pop_front();
      check($sformatf("event_kind[%0d]", d), k, ek);
      check($sformatf("event_cycle[%0d]", d), cyc, ec);
    end
  endtask

  // Monitor / consumer
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (avail[d] && !prev_avail[d]) rise_cyc[d] = cyc;
        prev_avail[d] = avail[d];
        rd_en[d] = 1'b0;
        if (read_on && avail[d]) begin
          rd_en[d] = 1'b1;
          if (exp_q[d].size() == 0) begin
            check($sformatf("unexpected_entry[%0d]", d), {1'b1, brk[d], ext[d], code[d]}, 0);
          end else begin
            logic [9:0] e;
            e = exp_q[d].pop_front();
            check($sformatf("entry[%0d]", d), {brk[d], ext[d], code[d]}, e);
          end
        end
        if (err_parity[d]) take_ev(d, 1);
        if (err_frame[d])  take_ev(d, 2);
        if (overflow[d])   take_ev(d, 3);
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the first n_edges bits of a frame (start, 8 data LSB-first,
  // parity, stop). Incomplete frames are expected to time out.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_val,
                            input int n_edges, input bit use_model, output int last_fall);
    logic [10:0] bits;
    bits = {stop_val, (~^b) ^ bad_par, b, 1'b0};
    last_fall = 0;
    for (int i = 0; i < n_edges; i++) begin
      ps2_data = bits[i];
      tick(HALF);
      ps2_clk = 1'b0;
      last_fall = cyc;
      if (use_model && i == 10) model_byte(b, !bad_par, stop_val, cyc);
      tick(HALF);
      ps2_clk = 1'b1;
    end
    if (use_model && n_edges < 11) model_timeout(last_fall);
    tick(1);
    ps2_data = 1'b1;
    tick(10);
    if (use_model && n_edges < 11) tick(T + F + 10);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int lf;
    send_frame(b, 1'b0, 1'b1, 11, 1'b1, lf);
  endtask

  task automatic spurious_edge();
    ps2_data = 1'b1;
    tick(HALF);
    ps2_clk = 1'b0;
    for (int d = 0; d < 2; d++) add_ev(d, 2, cyc + F + 3);
    tick(HALF);
    ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic drain(input string tag);
    read_on = 1'b1;
    tick(DEPTH + 6);
    read_on = 1'b0;
    tick(2);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_left[%0d]", tag, d), exp_q[d].size(), 0);
      check($sformatf("%s_avail[%0d]", tag, d), avail[d], 0);
    end
    tick(1);
  endtask

  initial begin
    int lf;
    tick(4);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_flags[%0d]", d),
            {avail[d], full[d], busy[d], err_parity[d], err_frame[d], overflow[d], ext[d], brk[d]}, 0);
      check($sformatf("reset_code[%0d]", d), code[d], 0);
    end
    tick(1);
    reset_n = 1'b1;
    tick(5);

    // Single frame 0x1C: head visible, exact avail latency, then one pop.
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1, lf);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("single_head[%0d]", d), {avail[d], brk[d], ext[d], code[d]}, {3'b100, 8'h1C});
      check($sformatf("avail_latency[%0d]", d), rise_cyc[d], lf + F + 4);
    end
    tick(1);
    drain("single");

    // Prefix merging versus raw bytes.
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    drain("prefix");

    // Parity error keeps a pending E0 from before? No: error precedes E0.
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b1, lf);
    send_byte(8'hE0); send_byte(8'h75);
    // Stop error between E0 and 0x75 clears the pending flag.
    send_byte(8'hE0);
    send_frame(8'h33, 1'b0, 1'b0, 11, 1'b1, lf);
    send_byte(8'h75);
    drain("errors");

    // Four data bits then silence: timeout, FSM back to idle, then recovery.
    send_frame(8'h55, 1'b0, 1'b1, 5, 1'b1, lf);
    @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("timeout_busy[%0d]", d), busy[d], 0);
    tick(1);
    send_byte(8'h29);
    drain("timeout");

    // Nine frames without reads: full, one overflow, first eight kept.
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("fifo_full[%0d]", d), full[d], 1);
    tick(1);
    drain("overflow");

    // Short low glitch on an idle bus.
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(20);
    @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("glitch_quiet[%0d]", d), {busy[d], avail[d]}, 0);
    tick(1);

    // Reset pulsed mid-frame.
    send_frame(8'hA5, 1'b0, 1'b1, 4, 1'b0, lf);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check($sformatf("midreset_flags[%0d]", d),
            {code[d], avail[d], full[d], busy[d], err_parity[d], err_frame[d], overflow[d], ext[d], brk[d]}, 0);
    tick(3);
    reset_n = 1'b1;
    tick(5);
    send_byte(8'h1C);
    drain("after_reset");

    // Randomised traffic with continuous reading.
    read_on = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int kind;
      logic [7:0] b;
      kind = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0: b = 8'hE0;
        1: b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      case (kind)
        6: send_frame(b, 1'b1, 1'b1, 11, 1'b1, lf);
        7: send_frame(b, 1'(~$urandom_range(0, 1)), 1'b0, 11, 1'b1, lf);
        8: send_frame(b, 1'b0, 1'b1, $urandom_range(1, 10), 1'b1, lf);
        9: spurious_edge();
        default: send_frame(b, 1'b0, 1'b1, 11, 1'b1, lf);
      endcase
    end
    tick(50);
    drain("random");

    for (int d = 0; d < 2; d++) check($sformatf("events_left[%0d]", d), ev_kind[d].size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
